// File: rtl/encoder_8x3_seq.sv
// Sequential 8-to-3 encoder.
// Accepts an 8-bit request vector over a valid/ready handshake, then emits
// the 3-bit index of every set bit, one per output handshake, in priority
// order (lowest index first, or highest first when MSB_FIRST=1).

module encoder_8x3_seq #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out,
  output logic       out_last,
  output logic       err_zero,
  output logic       busy
);

  typedef enum logic {
    IDLE,
    SERVE
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] pending_q, pending_d;
  logic       errZero_q, errZero_d;
  logic [2:0] index;
  logic       single;

  // Priority pick from the registered pending set; the last hit in scan order wins.
  always_comb begin
    index = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (MSB_FIRST) begin
        if (pending_q[i]) index = 3'(i);
      end else begin
        if (pending_q[7 - i]) index = 3'(7 - i);
      end
    end
  end

  // Exactly one bit left means the index on the output is the final one.
  assign single = (pending_q != 8'd0) && ((pending_q & (pending_q - 8'd1)) == 8'd0);

  // Next-state logic: accept in IDLE, retire one bit per handshake in SERVE.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    errZero_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && in_valid) begin
          if (in == 8'd0) begin
            errZero_d = 1'b1;
          end else begin
            pending_d = in;
            state_d   = SERVE;
          end
        end
      end
      SERVE: begin
        if (en && out_ready) begin
          pending_d = pending_q & ~(8'd1 << index);
          if (single) begin
            pending_d = 8'd0;
            state_d   = IDLE;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        pending_d = 8'd0;
      end
    endcase
  end

  // State registers with synchronous reset; reset discards any partial vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= 8'd0;
      errZero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      errZero_q <= errZero_d;
    end
  end

  assign busy      = (state_q == SERVE);
  assign in_ready  = (state_q == IDLE) && en && !rst;
  assign out_valid = busy && en;
  assign out       = index;
  assign out_last  = busy && single;
  assign err_zero  = errZero_q;

endmodule

// File: tb/tb_encoder_8x3_seq.sv
// Testbench for encoder_8x3_seq: two instances (LSB-first and MSB-first)
// share stimulus and are checked every cycle against a queue-based model.

module tb_encoder_8x3_seq;

  logic       clk;
  logic       rst;
  logic       en;
  logic       inValid;
  logic [7:0] inVec;
  logic       outReady;

  logic       inReadyL, outValidL, outLastL, errZeroL, busyL;
  logic [2:0] outL;
  logic       inReadyM, outValidM, outLastM, errZeroM, busyM;
  logic [2:0] outM;

  int errorCount = 0;
  int checkCount = 0;

  int  lsbQ[$];
  int  msbQ[$];
  bit  errExp = 1'b0;
  bit  checking = 1'b0;

  encoder_8x3_seq #(.MSB_FIRST(1'b0)) dutLsb (
    .clk(clk), .rst(rst), .en(en), .in_valid(inValid), .in_ready(inReadyL),
    .in(inVec), .out_valid(outValidL), .out_ready(outReady), .out(outL),
    .out_last(outLastL), .err_zero(errZeroL), .busy(busyL)
  );

  encoder_8x3_seq #(.MSB_FIRST(1'b1)) dutMsb (
    .clk(clk), .rst(rst), .en(en), .in_valid(inValid), .in_ready(inReadyM),
    .in(inVec), .out_valid(outValidM), .out_ready(outReady), .out(outM),
    .out_last(outLastM), .err_zero(errZeroM), .busy(busyM)
  );

  // Free-running clock, 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic v,
                               input logic [7:0] d, input logic rdy);
    @(posedge clk);
    #1;
    rst      = r;
    en       = e;
    inValid  = v;
    inVec    = d;
    outReady = rdy;
  endtask

  // Reference model: a vector becomes a list of its set indices in emission
  // order; each output handshake pops the head of the list.
  always @(posedge clk) begin
    if (rst) begin
      checking = 1'b1;
      lsbQ.delete();
      msbQ.delete();
      errExp = 1'b0;
    end else begin
      errExp = 1'b0;
      if (en) begin
        if (lsbQ.size() == 0) begin
          if (inValid) begin
            if (inVec == 8'd0) begin
              errExp = 1'b1;
            end else begin
              for (int i = 0; i < 8; i++) if (inVec[i]) lsbQ.push_back(i);
              for (int i = 7; i >= 0; i--) if (inVec[i]) msbQ.push_back(i);
            end
          end
        end else if (outReady) begin
          void'(lsbQ.pop_front());
          void'(msbQ.pop_front());
        end
      end
    end
  end

  // Compare every output of both instances away from the active edge.
  always @(negedge clk) begin
    logic       b;
    logic [7:0] expL;
    logic [7:0] expM;
    if (checking) begin
      b    = (lsbQ.size() != 0);
      expL = b ? 8'(lsbQ[0]) : 8'd0;
      expM = b ? 8'(msbQ[0]) : 8'd0;
      checkOutput("lsb.busy",      {7'd0, busyL},     {7'd0, b});
      checkOutput("lsb.out_valid", {7'd0, outValidL}, {7'd0, b && en});
      checkOutput("lsb.out",       {5'd0, outL},      expL);
      checkOutput("lsb.out_last",  {7'd0, outLastL},  {7'd0, b && lsbQ.size() == 1});
      checkOutput("lsb.in_ready",  {7'd0, inReadyL},  {7'd0, !b && en && !rst});
      checkOutput("lsb.err_zero",  {7'd0, errZeroL},  {7'd0, errExp});
      checkOutput("msb.busy",      {7'd0, busyM},     {7'd0, b});
      checkOutput("msb.out_valid", {7'd0, outValidM}, {7'd0, b && en});
      checkOutput("msb.out",       {5'd0, outM},      expM);
      checkOutput("msb.out_last",  {7'd0, outLastM},  {7'd0, b && msbQ.size() == 1});
      checkOutput("msb.in_ready",  {7'd0, inReadyM},  {7'd0, !b && en && !rst});
      checkOutput("msb.err_zero",  {7'd0, errZeroM},  {7'd0, errExp});
    end
  end

  // Directed scenarios first, then a long randomized run.
  initial begin
    logic [7:0] d;
    int         sel;
    rst = 1'b1; en = 1'b0; inValid = 1'b0; inVec = 8'd0; outReady = 1'b0;
    applyStimulus(1, 0, 0, 8'h00, 0);
    applyStimulus(0, 1, 1, 8'b1010_0100, 1);
    applyStimulus(0, 1, 0, 8'h00, 1);
    repeat (4) applyStimulus(0, 1, 0, 8'h00, 1);
    applyStimulus(0, 1, 1, 8'hFF, 1);
    applyStimulus(0, 1, 0, 8'h00, 1);
    repeat (9) applyStimulus(0, 1, 0, 8'h00, 1);
    applyStimulus(0, 1, 1, 8'h00, 1);
    applyStimulus(0, 1, 0, 8'h00, 1);
    applyStimulus(0, 1, 1, 8'b0001_0010, 0);
    repeat (3) applyStimulus(0, 1, 1, 8'hAA, 0);
    repeat (3) applyStimulus(0, 1, 0, 8'h00, 1);
    applyStimulus(0, 1, 1, 8'b1100_0000, 1);
    applyStimulus(0, 1, 0, 8'h00, 1);
    repeat (2) applyStimulus(0, 0, 1, 8'h0F, 1);
    repeat (3) applyStimulus(0, 1, 0, 8'h00, 1);
    applyStimulus(0, 1, 1, 8'hF0, 1);
    applyStimulus(0, 1, 0, 8'h00, 1);
    applyStimulus(1, 1, 0, 8'h00, 1);
    applyStimulus(0, 1, 1, 8'h01, 1);
    repeat (3) applyStimulus(0, 1, 0, 8'h00, 1);

    for (int n = 0; n < 3000; n++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0:       d = 8'h00;
        1:       d = 8'hFF;
        2:       d = 8'd1 << $urandom_range(0, 7);
        default: d = 8'($urandom);
      endcase
      applyStimulus($urandom_range(0, 79) == 0,
                    $urandom_range(0, 99) < 85,
                    $urandom_range(0, 1) == 1,
                    d,
                    $urandom_range(0, 99) < 70);
    end

    applyStimulus(0, 1, 0, 8'h00, 1);
    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
